instruction_decode_stage: RTL and testbench



---
 rtl/instruction_decode_stage.sv | 92 +++++++++
 tb/tb_instruction_decode_stage.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/instruction_decode_stage.sv
// instruction_decode_stage
//   ID stage of the 24-bit pipeline. It splits the IF/ID instruction into its
//   fields, builds the 5-bit control word and the immediate, and reads three
//   operands from a 16 x 24 register file. The result is registered into the
//   147-bit ID/EX word.
// Ports:
//   clk        rising-edge clock
//   rst        async active-low, clears bufferOut only
//   rstTotal   async active-low, clears bufferOut and every RF entry
//   en         ID/EX load enable (0 = hold)
//   inst, pc   instruction and its PC from IF/ID
//   WE, Rd, WD write-back port into the register file
//   bufferOut  registered ID/EX word
module instruction_decode_stage (
  input  logic         clk,
  input  logic         rst,
  input  logic         rstTotal,
  input  logic         en,
  input  logic [31:0]  inst,
  input  logic [23:0]  pc,
  input  logic         WE,
  input  logic [3:0]   Rd,
  input  logic [23:0]  WD,
  output logic [146:0] bufferOut
);

  localparam int NREG = 16;

  logic [NREG-1:0][23:0] rf;

  logic [1:0]  itype;
  logic [3:0]  opcode, rd_f, ra_f, rb_f;
  logic [4:0]  ctrl;
  logic [23:0] imm;
  logic [23:0] ra_d, rb_d, rd_d;
  logic [146:0] word;

  assign itype  = inst[31:30];
  assign opcode = inst[29:26];
  assign rd_f   = inst[25:22];
  assign ra_f   = inst[21:18];
  assign rb_f   = inst[17:14];

  // Control bits: {imm-as-B, branch, mem write, mem read, reg write}
  always_comb begin
    ctrl = 5'b00000;
    imm  = '0;
    case (itype)
      2'b00: ctrl = (inst == 32'h0) ? 5'b00000 : 5'b00001;
      2'b01: begin
        ctrl = 5'b10001;
        imm  = {6'b0, inst[17:0]};
      end
      2'b10: begin
        case (opcode)
          4'b0000: ctrl = 5'b00011;
          4'b0001: ctrl = 5'b00100;
          default: ctrl = 5'b00000;
        endcase
      end
      default: begin
        ctrl = 5'b11000;
        imm  = inst[23:0];
      end
    endcase
  end

  // Write-through: a same-cycle write-back to a read address forwards WD.
  always_comb begin
    ra_d = (WE && (Rd == ra_f)) ? WD : rf[ra_f];
    rb_d = (WE && (Rd == rb_f)) ? WD : rf[rb_f];
    rd_d = (WE && (Rd == rd_f)) ? WD : rf[rd_f];
  end

  assign word = {itype, pc, opcode, ctrl, 4'b0000,
                 ra_f, ra_d, rb_f, rb_d, rd_f, rd_d, imm};

  always_ff @(posedge clk or negedge rstTotal) begin
    if (!rstTotal) begin
      rf <= '0;
    end else if (WE) begin
      for (int i = 0; i < NREG; i++)
        if (Rd == 4'(i)) rf[i] <= WD;
    end
  end

  always_ff @(posedge clk or negedge rst or negedge rstTotal) begin
    if (!rst || !rstTotal) bufferOut <= '0;
    else if (en)           bufferOut <= word;
  end

endmodule

// File: tb/tb_instruction_decode_stage.sv
module tb_instruction_decode_stage;

  logic         clk = 1'b0;
  logic         rst, rstTotal, en, WE;
  logic [31:0]  inst;
  logic [23:0]  pc, WD;
  logic [3:0]   Rd;
  logic [146:0] bufferOut;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  instruction_decode_stage dut (
    .clk(clk), .rst(rst), .rstTotal(rstTotal), .en(en),
    .inst(inst), .pc(pc), .WE(WE), .Rd(Rd), .WD(WD),
    .bufferOut(bufferOut)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] mk(input logic [1:0] t, input logic [3:0] op,
                                     input logic [3:0] d, input logic [3:0] a,
                                     input logic [3:0] b);
    return {t, op, d, a, b, 14'd0};
  endfunction

  logic [146:0] held;

  initial begin
    rst = 1'b0; rstTotal = 1'b0; en = 1'b1; WE = 1'b0;
    inst = 32'h0; pc = 24'h0; Rd = 4'd0; WD = 24'd0;
    #1;
    chk("reset_buf_lo", bufferOut[31:0], 32'h0);
    chk("reset_buf_hi", {13'd0, bufferOut[146:128]}, 32'h0);
    @(negedge clk);
    rst = 1'b1; rstTotal = 1'b1;

    // every RF entry reads 0 after total reset
    for (int i = 0; i < 16; i++) begin
      inst = mk(2'b00, 4'd0, 4'd0, 4'(i), 4'd0);
      step();
      chk($sformatf("rf_zero_r%0d", i), {8'd0, bufferOut[103:80]}, 32'h0);
    end

    // not r1,r10
    inst = 32'h204A8000; pc = 24'h000123;
    step();
    chk("not_ctrl",  {27'd0, bufferOut[116:112]}, 32'b00001);
    chk("not_op",    {28'd0, bufferOut[120:117]}, 32'b1000);
    chk("not_ra",    {28'd0, bufferOut[107:104]}, 32'b0010);
    chk("not_rb",    {28'd0, bufferOut[79:76]},   32'b1010);
    chk("not_rd",    {28'd0, bufferOut[51:48]},   32'b0001);
    chk("not_imm",   {8'd0, bufferOut[23:0]},     32'd0);
    chk("not_pc",    {8'd0, bufferOut[144:121]},  32'h000123);
    chk("not_type",  {30'd0, bufferOut[146:145]}, 32'd0);
    chk("not_zero",  {28'd0, bufferOut[111:108]}, 32'd0);

    // div r10,r6,#15
    inst = 32'h5698000F;
    step();
    chk("div_ctrl", {27'd0, bufferOut[116:112]}, 32'b10001);
    chk("div_op",   {28'd0, bufferOut[120:117]}, 32'b0101);
    chk("div_ra",   {28'd0, bufferOut[107:104]}, 32'b0110);
    chk("div_rd",   {28'd0, bufferOut[51:48]},   32'b1010);
    chk("div_imm",  {8'd0, bufferOut[23:0]},     32'd15);
    chk("div_type", {30'd0, bufferOut[146:145]}, 32'd1);

    // ld r15,[r0+r4]
    inst = 32'h83C10000;
    step();
    chk("ld_ctrl", {27'd0, bufferOut[116:112]}, 32'b00011);
    chk("ld_op",   {28'd0, bufferOut[120:117]}, 32'b0000);
    chk("ld_ra",   {28'd0, bufferOut[107:104]}, 32'b0000);
    chk("ld_rb",   {28'd0, bufferOut[79:76]},   32'b0100);
    chk("ld_rd",   {28'd0, bufferOut[51:48]},   32'b1111);
    chk("ld_imm",  {8'd0, bufferOut[23:0]},     32'd0);

    // bg #26
    inst = 32'hD000001A;
    step();
    chk("br_ctrl", {27'd0, bufferOut[116:112]}, 32'b11000);
    chk("br_op",   {28'd0, bufferOut[120:117]}, 32'b0100);
    chk("br_imm",  {8'd0, bufferOut[23:0]},     32'd26);

    // NOP
    inst = 32'h0;
    step();
    chk("nop_ctrl", {27'd0, bufferOut[116:112]}, 32'b00000);
    chk("nop_op",   {28'd0, bufferOut[120:117]}, 32'b0000);

    // memory with an undefined opcode
    inst = mk(2'b10, 4'b0010, 4'd1, 4'd2, 4'd3);
    step();
    chk("mem_other_ctrl", {27'd0, bufferOut[116:112]}, 32'b00000);

    // RF write r5 = 1, then read via Ra
    WE = 1'b1; Rd = 4'd5; WD = 24'd1; inst = 32'h0;
    step();
    WE = 1'b0;
    inst = mk(2'b00, 4'd0, 4'd1, 4'd5, 4'd2);
    step();
    chk("rf_write_ra", {8'd0, bufferOut[103:80]}, 32'd1);

    // write-through r5 = 7 while Ra = 5
    WE = 1'b1; Rd = 4'd5; WD = 24'd7;
    step();
    chk("wt_ra", {8'd0, bufferOut[103:80]}, 32'd7);
    WE = 1'b0;
    step();
    chk("wt_stored", {8'd0, bufferOut[103:80]}, 32'd7);

    // store: RF[Rb] and RF[Rd] ports
    WE = 1'b1; Rd = 4'd2; WD = 24'h123456; inst = 32'h0;
    step();
    Rd = 4'd9; WD = 24'hABCDEF;
    step();
    WE = 1'b0;
    inst = mk(2'b10, 4'b0001, 4'd9, 4'd5, 4'd2);
    step();
    chk("st_ctrl", {27'd0, bufferOut[116:112]}, 32'b00100);
    chk("st_rb_d", {8'd0, bufferOut[75:52]},    32'h123456);
    chk("st_rd_d", {8'd0, bufferOut[47:24]},    32'hABCDEF);
    chk("st_ra_d", {8'd0, bufferOut[103:80]},   32'd7);

    // en = 0 holds; RF write still lands
    held = bufferOut;
    en = 1'b0;
    WE = 1'b1; Rd = 4'd3; WD = 24'h000042;
    inst = 32'hD000001A;
    step();
    WE = 1'b0;
    chk("hold_lo", bufferOut[31:0],  held[31:0]);
    chk("hold_ctrl", {27'd0, bufferOut[116:112]}, 32'b00100);
    en = 1'b1;
    inst = mk(2'b00, 4'd0, 4'd0, 4'd3, 4'd0);
    step();
    chk("hold_rf_wr", {8'd0, bufferOut[103:80]}, 32'h42);

    // rst: immediate clear, RF untouched
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_async", {27'd0, bufferOut[116:112]}, 32'd0);
    chk("rst_async_lo", bufferOut[31:0], 32'd0);
    step();
    chk("rst_prio_en", bufferOut[31:0], 32'd0);
    @(negedge clk);
    rst = 1'b1;
    inst = mk(2'b00, 4'd0, 4'd0, 4'd5, 4'd0);
    step();
    chk("rst_rf_kept", {8'd0, bufferOut[103:80]}, 32'd7);

    // rstTotal: clears RF as well
    @(negedge clk);
    rstTotal = 1'b0;
    #1;
    chk("rstT_async", bufferOut[31:0], 32'd0);
    @(negedge clk);
    rstTotal = 1'b1;
    step();
    chk("rstT_rf_clr", {8'd0, bufferOut[103:80]}, 32'd0);
    inst = mk(2'b10, 4'b0001, 4'd9, 4'd3, 4'd2);
    step();
    chk("rstT_rb_clr", {8'd0, bufferOut[75:52]}, 32'd0);
    chk("rstT_rd_clr", {8'd0, bufferOut[47:24]}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
